pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Owns the program counter register and sequences the PC next-address selection for the fetch stage of the pipelined processor. Arbitrates between sequential increment, branch/jump redirect, hazard stall, debug single-step and program halt. Drives the select line of the PC next-address mux, asserts fetch flush on redirect, and reports halt and cycle count to the debug unit.

Parameters:
BUS_WIDTH, 32, PC and target address width
PC_INC, 1, increment per fetch (instruction memory is word-addressed)
DRAIN_CYCLES, 4, cycles after HALT fetch until pipeline is empty (IF→WB)
CNT_WIDTH, 32, width of cycle counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
debug_mode  input  1  1 = step mode, 0 = continuous run
step  input  1  single-step request, 1-cycle pulse, honoured only in step mode
stall  input  1  hazard-unit stall, hold PC
redirect_valid  input  1  branch/jump taken this cycle
redirect_target  input  BUS_WIDTH  taken branch/jump address
halt_fetched  input  1  instruction currently in IF is HALT
pc  output  BUS_WIDTH  current PC (registered)
pc_sel  output  1  next-address mux select: 1 = redirect_target, 0 = pc+PC_INC
pc_write  output  1  PC register load enable this cycle
if_flush  output  1  flush IF/ID register (wrong-path instruction)
pipe_enable  output  1  global pipeline advance enable for the stage registers
halted  output  1  program finished, pipeline drained
cycle_count  output  CNT_WIDTH  cycles with pipe_enable=1 since reset

Behaviour:
- Reset (reset=0 at rising edge): pc=0, state=RUN, cycle_count=0, drain counter=0; pc_sel=0, pc_write=0, if_flush=0, pipe_enable=0, halted=0 during and for the first cycle after reset.
- States: RUN, DRAIN, HALTED.
- advance = (debug_mode ? step : 1); pipe_enable = advance & state!=HALTED.
- RUN, advance=1, priority: redirect_valid > stall > halt_fetched > sequential.
  - redirect_valid: pc_sel=1, pc_write=1, if_flush=1; pc←redirect_target next edge. Redirect wins over simultaneous stall and halt_fetched (HALT on wrong path is discarded).
  - stall (no redirect): pc_write=0, pc holds, if_flush=0.
  - halt_fetched: pc_write=0 (PC frozen on HALT address), state→DRAIN, drain counter←DRAIN_CYCLES-1.
  - otherwise: pc_sel=0, pc_write=1, pc←pc+PC_INC, modulo 2^BUS_WIDTH (wrap to 0, no flag).
- RUN, advance=0 (step mode, no step): pc_write=0, if_flush=0, pipe_enable=0; inputs ignored, nothing changes.
- DRAIN: pc_write=0, pc_sel=0; redirect_valid ignored (older branch cannot exist behind HALT; HALT follows delay-slot-free fetch). Counter decrements on each advance cycle; stall also ignored in DRAIN. When counter=0 and advance=1 → HALTED.
- HALTED: halted=1, pipe_enable=0, pc_write=0, if_flush=0; all inputs including step ignored; leaves only via reset.
- cycle_count increments on every cycle with pipe_enable=1; saturates at all-ones.
- debug_mode may toggle at any cycle; takes effect the same cycle (combinational into advance).
- step held high multiple cycles counts as one advance per cycle (bench/debug unit must pulse).
- Reset mid-DRAIN or in HALTED: immediate return to reset values next edge.
- Outputs pc_sel, pc_write, if_flush, pipe_enable are combinational from state and inputs; pc, halted, cycle_count registered. Zero-latency: redirect visible on pc one edge after redirect_valid.

Decomposition:
- Shared package/header: state encodings (ST_RUN=2'd0, ST_DRAIN=2'd1, ST_HALTED=2'd2), PC_SEL_SEQ/PC_SEL_REDIR constants, HALT opcode constant used by the IF decoder.
- One natural sub-module: the existing two-input PC mux instantiated for next-address selection (pc_sel → its select); adder and counter inline.

Test Plan:
- Continuous run, no events, 5 cycles after reset release → pc 0,1,2,3,4,5; pc_write=1; cycle_count=5.
- At pc=3 assert redirect_valid with target=0x40 plus stall same cycle → pc=0x40 next edge, if_flush=1 for that one cycle.
- stall high 3 cycles at pc=7 → pc stays 7, pc_write=0, cycle_count still increments; resumes 8 after stall drops.
- halt_fetched at pc=0x10 → pc frozen 0x10, halted rises exactly DRAIN_CYCLES(4) cycles later; later step/redirect ignored.
- debug_mode=1, three step pulses separated by idle cycles → pc advances exactly 3, pipe_enable high only on step cycles, cycle_count=3.
- pc=0xFFFFFFFF sequential → wraps to 0; reset=0 asserted in DRAIN → next edge pc=0, state RUN, halted=0, cycle_count=0.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the fetch-stage PC sequencer: FSM states, mux select
// values and the HALT opcode recognised by the IF decoder.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } seq_state_t;

    localparam logic PC_SEL_SEQ   = 1'b0;
    localparam logic PC_SEL_REDIR = 1'b1;

    localparam logic [6:0] HALT_OPCODE = 7'b111_1111;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the PC sequencer and the rest of the pipeline.
// The slave side is the sequencer; the master side drives events and observes.
interface pc_sequencer_if #(
    parameter int BUS_WIDTH = 32,
    parameter int CNT_WIDTH = 32
);
    logic                 debug_mode;
    logic                 step;
    logic                 stall;
    logic                 redirect_valid;
    logic [BUS_WIDTH-1:0] redirect_target;
    logic                 halt_fetched;
    logic [BUS_WIDTH-1:0] pc;
    logic                 pc_sel;
    logic                 pc_write;
    logic                 if_flush;
    logic                 pipe_enable;
    logic                 halted;
    logic [CNT_WIDTH-1:0] cycle_count;

    modport master (
        output debug_mode, step, stall, redirect_valid, redirect_target, halt_fetched,
        input  pc, pc_sel, pc_write, if_flush, pipe_enable, halted, cycle_count
    );

    modport slave (
        input  debug_mode, step, stall, redirect_valid, redirect_target, halt_fetched,
        output pc, pc_sel, pc_write, if_flush, pipe_enable, halted, cycle_count
    );
endinterface

// File: rtl/pc_sequencer_mux.sv
// Two-input next-address mux: sequential increment or taken redirect target.
module pc_sequencer_mux
    import pc_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] seq_addr,
    input  logic [WIDTH-1:0] redir_addr,
    input  logic             sel,
    output logic [WIDTH-1:0] next_addr
);

    assign next_addr = (sel == PC_SEL_REDIR) ? redir_addr : seq_addr;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner for the fetch stage: arbitrates redirect, stall, HALT
// drain and debug single-step, and counts cycles in which the pipeline advanced.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int BUS_WIDTH    = 32,
    parameter int PC_INC       = 1,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_WIDTH    = 32
) (
    input logic          clk,
    input logic          reset,
    pc_sequencer_if.slave bus
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    seq_state_t           state;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic [BUS_WIDTH-1:0] pc_q;
    logic [BUS_WIDTH-1:0] seq_pc;
    logic [BUS_WIDTH-1:0] next_pc;
    logic [CNT_WIDTH-1:0] cycle_cnt;
    logic                 halted_q;
    logic                 ready;
    logic                 active;
    logic                 advance;
    logic                 sel;
    logic                 write_en;
    logic                 flush;
    logic                 pipe_en;

    // Control outputs stay low while reset is held and for one cycle after it.
    assign active  = reset & ready;
    assign advance = bus.debug_mode ? bus.step : 1'b1;
    assign seq_pc  = pc_q + BUS_WIDTH'(PC_INC);

    always_comb begin
        sel      = PC_SEL_SEQ;
        write_en = 1'b0;
        flush    = 1'b0;
        pipe_en  = 1'b0;
        if (active && state != ST_HALTED) begin
            pipe_en = advance;
        end
        if (active && state == ST_RUN && advance) begin
            if (bus.redirect_valid) begin
                sel      = PC_SEL_REDIR;
                write_en = 1'b1;
                flush    = 1'b1;
            end else if (!bus.stall && !bus.halt_fetched) begin
                write_en = 1'b1;
            end
        end
    end

    pc_sequencer_mux #(.WIDTH(BUS_WIDTH)) u_pc_mux (
        .seq_addr   (seq_pc),
        .redir_addr (bus.redirect_target),
        .sel        (sel),
        .next_addr  (next_pc)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
            pc_q      <= '0;
            cycle_cnt <= '0;
            halted_q  <= 1'b0;
            ready     <= 1'b0;
        end else begin
            ready <= 1'b1;
            if (write_en) begin
                pc_q <= next_pc;
            end
            if (pipe_en && cycle_cnt != {CNT_WIDTH{1'b1}}) begin
                cycle_cnt <= cycle_cnt + 1'b1;
            end
            case (state)
                ST_RUN: begin
                    if (pipe_en && !bus.redirect_valid && !bus.stall && bus.halt_fetched) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= DRAIN_W'(DRAIN_CYCLES - 1);
                    end
                end
                ST_DRAIN: begin
                    if (pipe_en) begin
                        if (drain_cnt == '0) begin
                            state    <= ST_HALTED;
                            halted_q <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt - 1'b1;
                        end
                    end
                end
                ST_HALTED: begin
                    halted_q <= 1'b1;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_sel      = sel;
    assign bus.pc_write    = write_en;
    assign bus.if_flush    = flush;
    assign bus.pipe_enable = pipe_en;
    assign bus.halted      = halted_q;
    assign bus.cycle_count = cycle_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a randomized
// run, all compared against a behavioural model of the sequencing rules.
module tb_pc_sequencer;

    localparam int DRAIN = 4;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    pc_sequencer_if #(.BUS_WIDTH(32), .CNT_WIDTH(32)) bus ();

    pc_sequencer #(
        .BUS_WIDTH(32), .PC_INC(1), .DRAIN_CYCLES(DRAIN), .CNT_WIDTH(32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural view of the sequencer
    logic [31:0] m_pc;
    logic [31:0] m_cycles;
    logic        m_halted;
    logic        m_draining;
    int          m_drain_left;
    logic        m_fresh;

    logic        cur_rst;
    logic        cur_rv;
    logic        cur_stl;
    logic        cur_hf;
    logic [31:0] cur_rt;

    logic        exp_pc_sel;
    logic        exp_pc_write;
    logic        exp_if_flush;
    logic        exp_pipe_enable;
    logic [31:0] exp_pc;
    logic [31:0] exp_cycles;
    logic        exp_halted;

    task automatic apply(input logic dm, input logic st, input logic stl, input logic rv,
                         input logic [31:0] rt, input logic hf, input logic rst_n);
        logic run_ok;
        logic adv;
        logic redir;
        bus.debug_mode      = dm;
        bus.step            = st;
        bus.stall           = stl;
        bus.redirect_valid  = rv;
        bus.redirect_target = rt;
        bus.halt_fetched    = hf;
        reset               = rst_n;
        cur_rst = rst_n; cur_rv = rv; cur_stl = stl; cur_hf = hf; cur_rt = rt;
        #1;
        run_ok          = rst_n && !m_fresh;
        adv             = dm ? st : 1'b1;
        exp_pipe_enable = run_ok && adv && !m_halted;
        redir           = exp_pipe_enable && !m_draining && rv;
        exp_pc_sel      = redir;
        exp_if_flush    = redir;
        exp_pc_write    = redir || (exp_pipe_enable && !m_draining && !stl && !hf);
        exp_pc          = m_pc;
        exp_cycles      = m_cycles;
        exp_halted      = m_halted;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!cur_rst) begin
            m_pc = '0; m_cycles = '0; m_halted = 1'b0;
            m_draining = 1'b0; m_drain_left = 0; m_fresh = 1'b1;
        end else begin
            m_fresh = 1'b0;
            if (exp_pc_write) m_pc = exp_pc_sel ? cur_rt : m_pc + 32'd1;
            if (exp_pipe_enable && m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 32'd1;
            if (exp_pipe_enable) begin
                if (m_draining) begin
                    if (m_drain_left == 0) begin
                        m_halted = 1'b1;
                        m_draining = 1'b0;
                    end else begin
                        m_drain_left = m_drain_left - 1;
                    end
                end else if (!cur_rv && !cur_stl && cur_hf) begin
                    m_draining = 1'b1;
                    m_drain_left = DRAIN - 1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            apply(0, 0, 0, 0, 32'h0, 0, 1);
            tick();
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < 2; i++) begin
            apply(0, 0, 0, 0, 32'h0, 0, 0);
            tick();
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            apply(0, 0, 1, 1, 32'h55, 1, 0);
            checks++;
            if ({bus.pipe_enable, bus.pc_write, bus.if_flush, bus.pc_sel} !== 4'b0000) begin
                failures++;
                $display("[TB] FAIL reset_ctrl got=%b exp=0000",
                         {bus.pipe_enable, bus.pc_write, bus.if_flush, bus.pc_sel});
            end
            tick();
        end
        apply(0, 0, 0, 0, 32'h0, 0, 1);
        checks++;
        if (bus.pc !== 32'h0 || bus.halted !== 1'b0 || bus.cycle_count !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_state got pc=%h halted=%b cnt=%0d exp pc=0 halted=0 cnt=0",
                     bus.pc, bus.halted, bus.cycle_count);
        end
        checks++;
        if (bus.pc_write !== 1'b0 || bus.pipe_enable !== 1'b0) begin
            failures++;
            $display("[TB] FAIL first_cycle got pc_write=%b pipe_enable=%b exp 0 0",
                     bus.pc_write, bus.pipe_enable);
        end
        tick();
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 5; i++) begin
            apply(0, 0, 0, 0, 32'h0, 0, 1);
            checks++;
            if (bus.pc !== exp_pc || bus.pc_write !== 1'b1 || bus.pc_sel !== 1'b0) begin
                failures++;
                $display("[TB] FAIL seq_step got pc=%h wr=%b exp pc=%h wr=1",
                         bus.pc, bus.pc_write, exp_pc);
            end
            tick();
        end
        apply(0, 0, 0, 0, 32'h0, 0, 1);
        checks++;
        if (bus.pc !== 32'd5 || bus.cycle_count !== 32'd5) begin
            failures++;
            $display("[TB] FAIL seq_end got pc=%h cnt=%0d exp pc=5 cnt=5", bus.pc, bus.cycle_count);
        end
    endtask

    task automatic test_redirect_stall();
        do_reset();
        idle(4);
        apply(0, 0, 1, 1, 32'h40, 1, 1);
        checks++;
        if (bus.pc !== 32'd3 || bus.if_flush !== 1'b1 || bus.pc_sel !== 1'b1 || bus.pc_write !== 1'b1) begin
            failures++;
            $display("[TB] FAIL redirect_ctrl got pc=%h flush=%b sel=%b wr=%b exp pc=3 1 1 1",
                     bus.pc, bus.if_flush, bus.pc_sel, bus.pc_write);
        end
        tick();
        apply(0, 0, 0, 0, 32'h0, 0, 1);
        checks++;
        if (bus.pc !== 32'h40 || bus.if_flush !== 1'b0) begin
            failures++;
            $display("[TB] FAIL redirect_pc got pc=%h flush=%b exp pc=40 flush=0", bus.pc, bus.if_flush);
        end
        tick();
    endtask

    task automatic test_stall();
        apply(0, 0, 0, 1, 32'd7, 0, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 1, 0, 32'h0, 0, 1);
            checks++;
            if (bus.pc !== 32'd7 || bus.pc_write !== 1'b0 || bus.pipe_enable !== 1'b1 ||
                bus.cycle_count !== exp_cycles) begin
                failures++;
                $display("[TB] FAIL stall_hold got pc=%h wr=%b pe=%b cnt=%0d exp pc=7 wr=0 pe=1 cnt=%0d",
                         bus.pc, bus.pc_write, bus.pipe_enable, bus.cycle_count, exp_cycles);
            end
            tick();
        end
        apply(0, 0, 0, 0, 32'h0, 0, 1);
        tick();
        apply(0, 0, 0, 0, 32'h0, 0, 1);
        checks++;
        if (bus.pc !== 32'd8) begin
            failures++;
            $display("[TB] FAIL stall_resume got pc=%h exp pc=8", bus.pc);
        end
        tick();
    endtask

    task automatic test_halt();
        int edges;
        logic [31:0] frozen_cnt;
        apply(0, 0, 0, 1, 32'h10, 0, 1);
        tick();
        apply(0, 0, 0, 0, 32'h0, 1, 1);
        checks++;
        if (bus.pc !== 32'h10 || bus.pc_write !== 1'b0) begin
            failures++;
            $display("[TB] FAIL halt_fetch got pc=%h wr=%b exp pc=10 wr=0", bus.pc, bus.pc_write);
        end
        tick();
        edges = 0;
        apply(0, 0, 1'($urandom_range(1)), 1, 32'h99, 0, 1);
        while (bus.halted !== 1'b1 && edges < 20) begin
            checks++;
            if (bus.pc !== 32'h10 || bus.pc_write !== 1'b0 || bus.if_flush !== 1'b0) begin
                failures++;
                $display("[TB] FAIL drain_hold got pc=%h wr=%b flush=%b exp pc=10 0 0",
                         bus.pc, bus.pc_write, bus.if_flush);
            end
            tick();
            edges++;
            apply(0, 0, 1'($urandom_range(1)), 1, 32'h99, 0, 1);
        end
        checks++;
        if (edges !== DRAIN || exp_halted !== 1'b1) begin
            failures++;
            $display("[TB] FAIL halt_latency got=%0d exp=%0d", edges, DRAIN);
        end
        frozen_cnt = exp_cycles;
        for (int i = 0; i < 5; i++) begin
            apply(1'($urandom_range(1)), 1, 0, 1, $urandom, 1'($urandom_range(1)), 1);
            checks++;
            if (bus.halted !== 1'b1 || bus.pc !== 32'h10 || bus.pipe_enable !== 1'b0 ||
                bus.pc_write !== 1'b0 || bus.cycle_count !== frozen_cnt) begin
                failures++;
                $display("[TB] FAIL halted_hold got h=%b pc=%h pe=%b wr=%b cnt=%0d exp 1 10 0 0 %0d",
                         bus.halted, bus.pc, bus.pipe_enable, bus.pc_write, bus.cycle_count, frozen_cnt);
            end
            tick();
        end
    endtask

    task automatic test_step();
        logic pattern [8] = '{0, 1, 0, 0, 1, 0, 1, 0};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            apply(1, pattern[i], 0, 0, 32'h0, 0, 1);
            checks++;
            if (bus.pipe_enable !== exp_pipe_enable || bus.pc !== exp_pc) begin
                failures++;
                $display("[TB] FAIL step_cycle got pe=%b pc=%h exp pe=%b pc=%h",
                         bus.pipe_enable, bus.pc, exp_pipe_enable, exp_pc);
            end
            tick();
        end
        apply(1, 0, 0, 0, 32'h0, 0, 1);
        checks++;
        if (bus.pc !== 32'd3 || bus.cycle_count !== 32'd3) begin
            failures++;
            $display("[TB] FAIL step_total got pc=%h cnt=%0d exp pc=3 cnt=3", bus.pc, bus.cycle_count);
        end
        tick();
    endtask

    task automatic test_wrap_and_reset_in_drain();
        do_reset();
        idle(1);
        apply(0, 0, 0, 1, 32'hFFFF_FFFF, 0, 1);
        tick();
        apply(0, 0, 0, 0, 32'h0, 0, 1);
        tick();
        apply(0, 0, 0, 0, 32'h0, 1, 1);
        checks++;
        if (bus.pc !== 32'h0) begin
            failures++;
            $display("[TB] FAIL pc_wrap got pc=%h exp pc=0", bus.pc);
        end
        tick();
        idle(1);
        apply(0, 0, 0, 0, 32'h0, 0, 0);
        checks++;
        if (bus.pipe_enable !== 1'b0) begin
            failures++;
            $display("[TB] FAIL drain_reset_pe got=%b exp=0", bus.pipe_enable);
        end
        tick();
        apply(0, 0, 0, 0, 32'h0, 0, 1);
        checks++;
        if (bus.pc !== 32'h0 || bus.halted !== 1'b0 || bus.cycle_count !== 32'h0) begin
            failures++;
            $display("[TB] FAIL drain_reset got pc=%h h=%b cnt=%0d exp 0 0 0",
                     bus.pc, bus.halted, bus.cycle_count);
        end
        tick();
        apply(0, 0, 0, 0, 32'h0, 0, 1);
        checks++;
        if (bus.pc_write !== 1'b1) begin
            failures++;
            $display("[TB] FAIL run_after_reset got wr=%b exp wr=1", bus.pc_write);
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            apply(1'($urandom_range(3) == 0), 1'($urandom_range(1)), 1'($urandom_range(3) == 0),
                  1'($urandom_range(4) == 0), $urandom, 1'($urandom_range(24) == 0),
                  1'($urandom_range(59) != 0));
            checks++;
            if (bus.pc !== exp_pc || bus.pc_sel !== exp_pc_sel || bus.pc_write !== exp_pc_write ||
                bus.if_flush !== exp_if_flush || bus.pipe_enable !== exp_pipe_enable ||
                bus.halted !== exp_halted || bus.cycle_count !== exp_cycles) begin
                failures++;
                $display("[TB] FAIL random_%0d got pc=%h sel=%b wr=%b fl=%b pe=%b h=%b cnt=%0d exp pc=%h sel=%b wr=%b fl=%b pe=%b h=%b cnt=%0d",
                         i, bus.pc, bus.pc_sel, bus.pc_write, bus.if_flush, bus.pipe_enable,
                         bus.halted, bus.cycle_count, exp_pc, exp_pc_sel, exp_pc_write,
                         exp_if_flush, exp_pipe_enable, exp_halted, exp_cycles);
            end
            tick();
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        m_pc = '0; m_cycles = '0; m_halted = 1'b0;
        m_draining = 1'b0; m_drain_left = 0; m_fresh = 1'b1;
        bus.debug_mode = 1'b0; bus.step = 1'b0; bus.stall = 1'b0;
        bus.redirect_valid = 1'b0; bus.redirect_target = '0; bus.halt_fetched = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_sequential();
        test_redirect_stall();
        test_stall();
        test_halt();
        test_step();
        test_wrap_and_reset_in_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout got=running exp=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
